// File: rtl/stream_fifo_pkg.sv
// Shared sizing helpers, parameter legality check and handshake-op encoding for stream_fifo.
package stream_fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit params_ok(input int unsigned depth, input int unsigned af_level,
                                   input int unsigned ae_level);
    return (depth >= 2) && (af_level >= 1) && (af_level <= depth) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// Valid/ready stream bundle; master drives valid/data, slave drives ready.
interface stream_fifo_if #(
  parameter int unsigned WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stream_fifo_ptr.sv
// Pointer register counting 0..DEPTH-1 with explicit wrap, so any DEPTH works.
module stream_fifo_ptr
  import stream_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        inc,
  input  logic                        clr,
  output logic [ptr_width(DEPTH)-1:0] ptr
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/stream_fifo.sv
// Synchronous valid/ready FIFO with occupancy count and almost-full/empty flags.
// Optional synchronous flush port enabled by defining STREAM_FIFO_FLUSH_EN.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  stream_fifo_if.slave                in_if,
  stream_fifo_if.master               out_if,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        almost_full,
  output logic                        almost_empty
`ifdef STREAM_FIFO_FLUSH_EN
  ,
  input  logic                        flush
`endif
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  if (!params_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("stream_fifo: illegal parameters DEPTH=%0d AF_LEVEL=%0d AE_LEVEL=%0d",
           DEPTH, AF_LEVEL, AE_LEVEL);
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             flush_i;
  logic             push;
  logic             pop;
  fifo_op_e         op;

`ifdef STREAM_FIFO_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Flush masks both handshakes so nothing completes in the clearing cycle.
  assign in_if.ready  = ~flush_i & (count != CW'(DEPTH));
  assign out_if.valid = ~flush_i & (count != '0);
  assign push         = in_if.valid & in_if.ready;
  assign pop          = out_if.valid & out_if.ready;
  assign out_if.data  = mem[rd_ptr];

  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  always_comb begin
    op = fifo_op_e'({pop, push});
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_if.data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (flush_i) begin
      count <= '0;
    end else begin
      case (op)
        OP_PUSH: count <= count + CW'(1);
        OP_POP:  count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  stream_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push),
    .clr   (flush_i),
    .ptr   (wr_ptr)
  );

  stream_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop),
    .clr   (flush_i),
    .ptr   (rd_ptr)
  );

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo (DEPTH=5, AF=4, AE=1) with a queue scoreboard and count model.
module tb_stream_fifo;

  logic       clk;
  logic       reset;
  logic [2:0] count;
  logic       almost_full;
  logic       almost_empty;
`ifdef STREAM_FIFO_FLUSH_EN
  logic       flush;
`endif

  stream_fifo_if #(.WIDTH(8)) in_if ();
  stream_fifo_if #(.WIDTH(8)) out_if ();

  stream_fifo #(
    .WIDTH    (8),
    .DEPTH    (5),
    .AF_LEVEL (4),
    .AE_LEVEL (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_if        (in_if),
    .out_if       (out_if),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef STREAM_FIFO_FLUSH_EN
    ,
    .flush        (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sb[$];
  bit         last_push;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    int unsigned n;
    n = sb.size();
    chk({tag, "_count"}, 32'(count), 32'(n));
    chk({tag, "_af"}, 32'(almost_full), 32'(n >= 4));
    chk({tag, "_ae"}, 32'(almost_empty), 32'(n <= 1));
  endtask

  // Called at a negedge; checks handshake outputs just before the edge, then state after it.
  task automatic cycle(input bit iv, input logic [7:0] din, input bit ordy);
    bit         do_push;
    bit         do_pop;
    logic [7:0] exp_d;
    in_if.valid  = iv;
    in_if.data   = din;
    out_if.ready = ordy;
    #4;
    chk("in_ready", 32'(in_if.ready), 32'(sb.size() != 5));
    chk("out_valid", 32'(out_if.valid), 32'(sb.size() != 0));
    do_pop  = ordy && (sb.size() != 0);
    do_push = iv && (sb.size() != 5);
    if (do_pop) begin
      exp_d = sb.pop_front();
      chk("out_data", 32'(out_if.data), 32'(exp_d));
    end
    if (do_push) sb.push_back(din);
    last_push = do_push;
    @(posedge clk);
    @(negedge clk);
    chk_state("post");
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      cycle(1'b0, 8'h00, 1'b1);
      guard++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int guard;
    reset        = 1'b1;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;
`ifdef STREAM_FIFO_FLUSH_EN
    flush        = 1'b0;
`endif
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_if.ready), 32'd1);
    chk("rst_out_valid", 32'(out_if.valid), 32'd0);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_af", 32'(almost_full), 32'd0);
    @(negedge clk);

    // Fill to full, hold an extra push off, then drain in order.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
    chk("full_count", 32'(count), 32'd5);
    cycle(1'b1, 8'h15, 1'b0);
    chk("held_not_taken", 32'(last_push), 32'd0);
    drain();
    chk("empty_out_valid", 32'(out_if.valid), 32'd0);

    // Single push into empty: visible only after the edge.
    cycle(1'b1, 8'hA5, 1'b0);
    chk("lat_out_valid", 32'(out_if.valid), 32'd1);
    chk("lat_out_data", 32'(out_if.data), 32'hA5);
    drain();

    // Random handshakes across pointer wrap.
    sent  = 0;
    guard = 0;
    while (sent < 13 && guard < 300) begin
      cycle(1'($urandom_range(0, 1)), 8'(8'h60 + sent), 1'($urandom_range(0, 1)));
      if (last_push) sent++;
      guard++;
    end
    chk("rand_budget", 32'(sent), 32'd13);
    drain();

    // Pop while full: count drops, in_ready returns only on the next cycle.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
    cycle(1'b1, 8'h77, 1'b1);
    chk("full_pop_count", 32'(count), 32'd4);
    cycle(1'b0, 8'h00, 1'b0);
    drain();

    // Asynchronous reset between edges.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0);
    in_if.valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_out_valid", 32'(out_if.valid), 32'd0);
    chk("arst_in_ready", 32'(in_if.ready), 32'd1);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_state("after_arst");

`ifdef STREAM_FIFO_FLUSH_EN
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
    flush        = 1'b1;
    in_if.valid  = 1'b1;
    in_if.data   = 8'h99;
    out_if.ready = 1'b1;
    #4;
    chk("flush_in_ready", 32'(in_if.ready), 32'd0);
    chk("flush_out_valid", 32'(out_if.valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    sb.delete();
    chk("flush_count", 32'(count), 32'd0);
    cycle(1'b1, 8'h42, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
